delivery_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the delivery game top; sits between the board push-buttons/switches and the game's `jogar` and `botoes[6:0]` inputs.
- Synchronises each raw input, debounces it, and emits clean single-cycle press pulses. The game FSM and datapath therefore see exactly one event per physical press.
- Optional hold-to-repeat on movement buttons, so a held direction keeps moving the player.

---
 rtl/delivery_input_conditioner_pkg.sv | 30 +++
 rtl/delivery_input_conditioner_debounce_channel.sv | 107 ++++++++++
 rtl/delivery_input_conditioner.sv | 63 ++++++
 tb/tb_delivery_input_conditioner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/delivery_input_conditioner_pkg.sv
// Shared constants for the delivery game input front-end.
// Holds clock-derived timing defaults, button index names and the
// auto-repeat phase type used by every conditioning channel.
package delivery_input_conditioner_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;

    // 20 ms debounce, 500 ms first repeat, 150 ms repeat period
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 50;
    localparam int unsigned DEFAULT_REPEAT_DELAY    = CLK_FREQ_HZ / 2;
    localparam int unsigned DEFAULT_REPEAT_PERIOD   = (CLK_FREQ_HZ / 20) * 3;

    localparam int unsigned DEFAULT_N_BUTTONS = 7;

    // Button index names within botoes[6:0]
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    // Only the four movement buttons auto-repeat by default
    localparam logic [DEFAULT_N_BUTTONS-1:0] DEFAULT_REPEAT_MASK = 7'b0001111;

    // Auto-repeat phase: waiting for first repeat, or in steady repeat
    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } phase_e;

endpackage

// File: rtl/delivery_input_conditioner_debounce_channel.sv
// One input channel: 2-FF synchroniser, counter debounce, registered
// press pulse on the 0->1 edge of the stable level and, when REPEAT_EN=1,
// hold-to-repeat pulses.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset
//   raw    - asynchronous raw input
//   level  - debounced level, 1 = held
//   pulse  - one-cycle press / repeat pulse
module debounce_channel
    import delivery_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW   = $clog2(HMAX + 1);
    // Sync flops clear to the idle raw level so an idle active-low
    // input is not briefly seen as pressed after reset.
    localparam logic        IDLE_RAW = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    logic          sample_c;
    logic          s_q, s_d;
    logic [CW-1:0] c_q, c_d;
    logic [HW-1:0] h_q, h_d;
    phase_e        phase_q, phase_d;
    logic          pulse_d;
    logic          press_c;
    logic          repeat_c;

    assign sample_c = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Next-state: debounce counter, hold counter, repeat phase and pulse
    always_comb begin
        s_d      = s_q;
        c_d      = '0;
        h_d      = '0;
        phase_d  = PH_DELAY;
        press_c  = 1'b0;
        repeat_c = 1'b0;
        pulse_d  = 1'b0;

        // A sample matching S clears the count; D consecutive mismatches toggle S
        if (sample_c != s_q) begin
            if (c_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                s_d = ~s_q;
            end else begin
                c_d = c_q + 1'b1;
            end
        end

        press_c = s_d & ~s_q;

        // Hold counting only while the level stays high; press edge and
        // release both leave H=0 / PH_DELAY via the defaults above.
        if (REPEAT_EN && s_q && s_d) begin
            h_d     = h_q + 1'b1;
            phase_d = phase_q;
            if (phase_q == PH_DELAY && h_q == HW'(REPEAT_DELAY - 1)) begin
                repeat_c = 1'b1;
                h_d      = '0;
                phase_d  = PH_PERIOD;
            end else if (phase_q == PH_PERIOD && h_q == HW'(REPEAT_PERIOD - 1)) begin
                repeat_c = 1'b1;
                h_d      = '0;
            end
        end

        pulse_d = press_c | repeat_c;
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
            s_q     <= 1'b0;
            c_q     <= '0;
            h_q     <= '0;
            phase_q <= PH_DELAY;
            pulse   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            s_q     <= s_d;
            c_q     <= c_d;
            h_q     <= h_d;
            phase_q <= phase_d;
            pulse   <= pulse_d;
        end
    end

    assign level = s_q;

endmodule

// File: rtl/delivery_input_conditioner.sv
// Input conditioner in front of the delivery game: synchronises, debounces
// and pulse-shapes the start button and the game buttons, with optional
// hold-to-repeat on masked buttons.
// Ports:
//   clock, reset    - system clock, synchronous active-high reset
//   jogar_raw       - raw start button
//   botoes_raw      - raw game buttons
//   jogar           - one-cycle press pulse (never repeats)
//   botoes          - one-cycle press / repeat pulses
//   botoes_nivel    - debounced button levels
//   db_jogar_nivel  - debounced start-button level
module delivery_input_conditioner
    import delivery_input_conditioner_pkg::*;
#(
    parameter int unsigned          N_BUTTONS       = DEFAULT_N_BUTTONS,
    parameter int unsigned          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned          REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned          REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(DEFAULT_REPEAT_MASK),
    parameter bit                   ACTIVE_LOW      = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 jogar_raw,
    input  logic [N_BUTTONS-1:0] botoes_raw,
    output logic                 jogar,
    output logic [N_BUTTONS-1:0] botoes,
    output logic [N_BUTTONS-1:0] botoes_nivel,
    output logic                 db_jogar_nivel
);

    localparam int unsigned NCH = N_BUTTONS + 1;
    // Top channel is jogar, which never auto-repeats
    localparam logic [NCH-1:0] REPEAT_EN_ALL = {1'b0, REPEAT_MASK};

    logic [NCH-1:0] raw_all;
    logic [NCH-1:0] level_all;
    logic [NCH-1:0] pulse_all;

    assign raw_all = {jogar_raw, botoes_raw};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN_ALL[i]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .raw   (raw_all[i]),
            .level (level_all[i]),
            .pulse (pulse_all[i])
        );
    end

    assign botoes         = pulse_all[N_BUTTONS-1:0];
    assign jogar          = pulse_all[N_BUTTONS];
    assign botoes_nivel   = level_all[N_BUTTONS-1:0];
    assign db_jogar_nivel = level_all[N_BUTTONS];

endmodule

// File: tb/tb_delivery_input_conditioner.sv
// Bench for delivery_input_conditioner: directed stimulus, a window-based
// behavioural model checked every cycle, plus literal expectations.
module tb_delivery_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int NB = 7;
    localparam logic [7:0] MASK_M = 8'b0000_1111;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          jogar_raw = 1'b0;
    logic [NB-1:0] botoes_raw = '0;
    logic          jogar;
    logic [NB-1:0] botoes;
    logic [NB-1:0] botoes_nivel;
    logic          db_jogar_nivel;

    int checks = 0;
    int failures = 0;

    delivery_input_conditioner #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (7'b0001111),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .jogar_raw      (jogar_raw),
        .botoes_raw     (botoes_raw),
        .jogar          (jogar),
        .botoes         (botoes),
        .botoes_nivel   (botoes_nivel),
        .db_jogar_nivel (db_jogar_nivel)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // A channel's level flips once the last D samples seen by the debouncer
    // (raw delayed two edges, zero just after reset) all disagree with it.
    // Pulses: at the press edge, then RD edges later, then every RP edges.
    logic [7:0] samp [0:4095];
    logic [7:0] s_m = '0;
    logic [7:0] pulse_m = '0;
    int         press_e [8];
    int         e = 0;
    int         last_rst = -100;
    bit         model_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            last_rst = e;
            s_m      = '0;
            pulse_m  = '0;
        end else begin
            samp[e] = {jogar_raw, botoes_raw};
            for (int ch = 0; ch < 8; ch++) begin
                bit all_diff;
                all_diff = (e - D + 1 > last_rst);
                for (int j = 0; j < D; j++) begin
                    int  t;
                    logic v;
                    t = e - j;
                    v = (t - 2 > last_rst) ? samp[t-2][ch] : 1'b0;
                    if (v == s_m[ch]) all_diff = 0;
                end
                pulse_m[ch] = 1'b0;
                if (all_diff) begin
                    s_m[ch] = ~s_m[ch];
                    if (s_m[ch]) begin
                        press_e[ch] = e;
                        pulse_m[ch] = 1'b1;
                    end
                end else if (s_m[ch] && MASK_M[ch]) begin
                    int d;
                    d = e - press_e[ch];
                    if (d >= RD && ((d - RD) % RP) == 0) pulse_m[ch] = 1'b1;
                end
            end
        end
        e++;
        model_valid = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (model_valid) begin
            checks++;
            if (botoes !== pulse_m[6:0]) begin
                failures++;
                $display("FAIL model_botoes edge=%0d got=%b exp=%b", e - 1, botoes, pulse_m[6:0]);
            end
            checks++;
            if (jogar !== pulse_m[7]) begin
                failures++;
                $display("FAIL model_jogar edge=%0d got=%b exp=%b", e - 1, jogar, pulse_m[7]);
            end
            checks++;
            if (botoes_nivel !== s_m[6:0]) begin
                failures++;
                $display("FAIL model_nivel edge=%0d got=%b exp=%b", e - 1, botoes_nivel, s_m[6:0]);
            end
            checks++;
            if (db_jogar_nivel !== s_m[7]) begin
                failures++;
                $display("FAIL model_jogar_nivel edge=%0d got=%b exp=%b", e - 1, db_jogar_nivel, s_m[7]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    initial begin
        // Reset
        step(3);
        chk("reset_botoes", 8'(botoes), 8'h00);
        chk("reset_nivel", 8'(botoes_nivel), 8'h00);
        chk("reset_jogar", {6'd0, jogar, db_jogar_nivel}, 8'h00);
        reset = 1'b0;
        step(3);

        // Clean press on bit 2 (repeat-enabled)
        botoes_raw[2] = 1'b1;
        step(5);
        chk("press2_early", 8'(botoes), 8'h00);
        step(1);
        chk("press2_pulse", 8'(botoes), 8'h04);
        chk("press2_nivel", 8'(botoes_nivel), 8'h04);
        step(1);
        chk("press2_single", 8'(botoes), 8'h00);
        step(9);
        chk("press2_repeat1", 8'(botoes), 8'h04);
        step(15);
        botoes_raw[2] = 1'b0;
        step(12);
        chk("press2_released", 8'(botoes_nivel), 8'h00);

        // Auto-repeat on bit 0
        botoes_raw[0] = 1'b1;
        step(6);
        chk("rep0_accept", 8'(botoes), 8'h01);
        step(10);
        chk("rep0_plus10", 8'(botoes), 8'h01);
        step(5);
        chk("rep0_plus15", 8'(botoes), 8'h01);
        step(25);
        botoes_raw[0] = 1'b0;
        step(5);
        chk("rep0_last_repeat", 8'(botoes), 8'h01);
        chk("rep0_still_held", 8'(botoes_nivel), 8'h01);
        step(1);
        chk("rep0_release_nivel", 8'(botoes_nivel), 8'h00);
        step(10);

        // Bounce rejection on jogar
        jogar_raw = 1'b1; step(1);
        jogar_raw = 1'b0; step(1);
        jogar_raw = 1'b1; step(1);
        jogar_raw = 1'b1; step(1);
        jogar_raw = 1'b0; step(1);
        jogar_raw = 1'b1; step(1);
        jogar_raw = 1'b0;
        step(12);
        chk("bounce_nivel", {7'd0, db_jogar_nivel}, 8'h00);
        jogar_raw = 1'b1;
        step(3);
        jogar_raw = 1'b0;
        step(10);
        chk("glitch_nivel", {7'd0, db_jogar_nivel}, 8'h00);

        // Non-repeat channel together with jogar
        botoes_raw[5] = 1'b1;
        jogar_raw     = 1'b1;
        step(6);
        chk("nr_botoes", 8'(botoes), 8'h20);
        chk("nr_jogar", {7'd0, jogar}, 8'h01);
        step(10);
        chk("nr_no_repeat", {jogar, botoes}, 8'h00);
        step(34);
        botoes_raw[5] = 1'b0;
        jogar_raw     = 1'b0;
        step(12);

        // Simultaneous press on bits 1 and 6
        botoes_raw[1] = 1'b1;
        botoes_raw[6] = 1'b1;
        step(6);
        chk("simul_pulse", 8'(botoes), 8'h42);
        step(1);
        chk("simul_one_cycle", 8'(botoes), 8'h00);
        step(7);
        botoes_raw[1] = 1'b0;
        botoes_raw[6] = 1'b0;
        step(12);

        // Reset mid-count on bit 3
        botoes_raw[3] = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        chk("midrst_botoes", 8'(botoes), 8'h00);
        chk("midrst_nivel", 8'(botoes_nivel), 8'h00);
        reset = 1'b0;
        step(5);
        chk("midrst_not_early", 8'(botoes), 8'h00);
        step(1);
        chk("midrst_pulse", 8'(botoes), 8'h08);
        chk("midrst_nivel_up", 8'(botoes_nivel), 8'h08);
        step(3);
        botoes_raw[3] = 1'b0;
        step(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
